mont_mul_arbiter: RTL and testbench

//  Shares one 4-stage Montgomery multiply/reduce pipe between two requesters (r0 = NTT butterfly, r1 = pointwise basemul).

---
 rtl/kyber_pkg.sv | 23 ++
 rtl/mont_mul_arbiter_if.sv | 31 +++
 rtl/mont_tag_pipe.sv | 38 +++
 rtl/mont_mul_arbiter.sv | 102 ++++++++++
 tb/tb_mont_mul_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and types for the Montgomery multiplier and its arbiter.
package kyber_pkg;

    localparam int unsigned COEFF_W     = 16;
    localparam int unsigned TAG_W       = 9;
    localparam int unsigned MUL_LATENCY = 4;
    localparam int unsigned MAX_BURST   = 8;
    localparam int unsigned BURST_W     = $clog2(MAX_BURST);

    localparam int KYBER_Q     = 3329;
    localparam int MONT_QINV   = 62209;
    localparam int MONT_R_MODQ = 2285;

    typedef logic [COEFF_W-1:0] coeff_t;
    typedef logic [TAG_W-1:0]   tag_t;

    typedef enum logic [1:0] {
        StIdle,
        StGnt0,
        StGnt1
    } arb_state_e;

endpackage

// File: rtl/mont_mul_arbiter_if.sv
// Requester, result and shared-multiplier signals of the Montgomery multiply arbiter.
interface mont_mul_arbiter_if;
    import kyber_pkg::*;

    logic   r0_valid, r0_ready;
    coeff_t r0_a, r0_b;
    tag_t   r0_tag;
    logic   r1_valid, r1_ready;
    coeff_t r1_a, r1_b;
    tag_t   r1_tag;

    logic   r0_res_valid, r1_res_valid;
    coeff_t r0_res, r1_res;
    tag_t   r0_res_tag, r1_res_tag;

    coeff_t mul_a, mul_b, mul_p;
    logic   busy;

    modport master (
        output r0_valid, r0_a, r0_b, r0_tag, r1_valid, r1_a, r1_b, r1_tag, mul_p,
        input  r0_ready, r1_ready, r0_res_valid, r0_res, r0_res_tag,
        input  r1_res_valid, r1_res, r1_res_tag, mul_a, mul_b, busy
    );

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_tag, r1_valid, r1_a, r1_b, r1_tag, mul_p,
        output r0_ready, r1_ready, r0_res_valid, r0_res, r0_res_tag,
        output r1_res_valid, r1_res, r1_res_tag, mul_a, mul_b, busy
    );

endinterface

// File: rtl/mont_tag_pipe.sv
// Fixed-latency {fire, owner, tag} delay line that tracks beats through the multiplier.
module mont_tag_pipe #(
    parameter int unsigned Depth = 4,
    parameter int unsigned TagW  = 9
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_fire,
    input  logic            i_owner,
    input  logic [TagW-1:0] i_tag,
    output logic            o_fire,
    output logic            o_owner,
    output logic [TagW-1:0] o_tag,
    output logic            o_any
);

    logic [Depth-1:0]           r_fire;
    logic [Depth-1:0]           r_owner;
    logic [Depth-1:0][TagW-1:0] r_tag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fire  <= '0;
            r_owner <= '0;
            r_tag   <= '0;
        end else begin
            r_fire  <= {r_fire[Depth-2:0], i_fire};
            r_owner <= {r_owner[Depth-2:0], i_owner};
            r_tag   <= {r_tag[Depth-2:0], i_tag};
        end
    end

    assign o_fire  = r_fire[Depth-1];
    assign o_owner = r_owner[Depth-1];
    assign o_tag   = r_tag[Depth-1];
    assign o_any   = |r_fire;

endmodule

// File: rtl/mont_mul_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one fixed-latency Montgomery pipe between two requesters.
module mont_mul_arbiter
    import kyber_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    mont_mul_arbiter_if.slave bus
);

    localparam logic [BURST_W-1:0] BurstLast = BURST_W'(MAX_BURST - 1);

    arb_state_e         r_state;
    logic               r_last_served;
    logic [BURST_W-1:0] r_burst_cnt;

    logic       w_fire0, w_fire1, w_fire, w_owner;
    logic       w_own_valid, w_oth_valid;
    arb_state_e w_oth_state;
    tag_t       w_tag, w_res_tag;
    logic       w_res_fire, w_res_owner, w_pipe_any;

    assign bus.r0_ready = (r_state == StGnt0);
    assign bus.r1_ready = (r_state == StGnt1);
    assign w_fire0      = bus.r0_valid && bus.r0_ready;
    assign w_fire1      = bus.r1_valid && bus.r1_ready;
    assign w_fire       = w_fire0 || w_fire1;
    assign w_owner      = w_fire1;
    assign w_tag        = w_fire1 ? bus.r1_tag : bus.r0_tag;

    assign w_own_valid  = (r_state == StGnt1) ? bus.r1_valid : bus.r0_valid;
    assign w_oth_valid  = (r_state == StGnt1) ? bus.r0_valid : bus.r1_valid;
    assign w_oth_state  = (r_state == StGnt1) ? StGnt0 : StGnt1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_last_served <= 1'b1;
            r_burst_cnt   <= '0;
        end else begin
            if (w_fire) r_last_served <= w_owner;
            case (r_state)
                StIdle: begin
                    // Tie goes to whoever was not served last.
                    if (bus.r0_valid && (!bus.r1_valid || r_last_served)) r_state <= StGnt0;
                    else if (bus.r1_valid)                                r_state <= StGnt1;
                end
                StGnt0, StGnt1: begin
                    if (w_fire && (r_burst_cnt == BurstLast) && w_oth_valid) begin
                        r_state     <= w_oth_state;
                        r_burst_cnt <= '0;
                    end else if (!w_own_valid && w_oth_valid) begin
                        r_state     <= w_oth_state;
                        r_burst_cnt <= '0;
                    end else if (!w_own_valid) begin
                        r_state     <= StIdle;
                        r_burst_cnt <= '0;
                    end else if (r_burst_cnt != BurstLast) begin
                        r_burst_cnt <= r_burst_cnt + BURST_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // The multiplier advances every cycle, so non-firing cycles must present zeros.
    always_comb begin
        bus.mul_a = '0;
        bus.mul_b = '0;
        if (w_fire0) begin
            bus.mul_a = bus.r0_a;
            bus.mul_b = bus.r0_b;
        end else if (w_fire1) begin
            bus.mul_a = bus.r1_a;
            bus.mul_b = bus.r1_b;
        end
    end

    mont_tag_pipe #(
        .Depth (MUL_LATENCY),
        .TagW  (TAG_W)
    ) u_tag_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .i_fire  (w_fire),
        .i_owner (w_owner),
        .i_tag   (w_tag),
        .o_fire  (w_res_fire),
        .o_owner (w_res_owner),
        .o_tag   (w_res_tag),
        .o_any   (w_pipe_any)
    );

    assign bus.r0_res_valid = w_res_fire && !w_res_owner;
    assign bus.r1_res_valid = w_res_fire && w_res_owner;
    assign bus.r0_res       = bus.mul_p;
    assign bus.r1_res       = bus.mul_p;
    assign bus.r0_res_tag   = w_res_tag;
    assign bus.r1_res_tag   = w_res_tag;
    assign bus.busy         = (r_state != StIdle) || w_pipe_any;

endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Directed bench for mont_mul_arbiter with a behavioural 4-stage Montgomery multiplier.
module tb_mont_mul_arbiter;
    import kyber_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mont_mul_arbiter_if bus ();

    mont_mul_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mont(input logic signed [15:0] a, input logic signed [15:0] b);
        int t, u;
        logic signed [15:0] m;
        t = int'(a) * int'(b);
        m = 16'(t * MONT_QINV);
        u = t - int'(m) * KYBER_Q;
        return 16'(u >>> 16);
    endfunction

    // Multiplier model: operands presented in cycle t give mul_p in cycle t+4.
    logic [15:0] mp [4] = '{16'd0, 16'd0, 16'd0, 16'd0};
    always @(posedge clk) begin
        mp[0] <= mont(bus.mul_a, bus.mul_b);
        mp[1] <= mp[0];
        mp[2] <= mp[1];
        mp[3] <= mp[2];
    end
    assign bus.mul_p = mp[3];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [15:0] a; logic [15:0] b; logic [8:0] tag; } beat_t;
    typedef struct { int cyc; bit owner; logic [8:0] tag; logic [15:0] res; } ev_t;
    typedef struct packed { logic fire; logic owner; logic [8:0] tag; logic [15:0] val; } exp_t;
    typedef struct { bit owner; logic [15:0] a; logic [15:0] b; logic [8:0] tag; int exp_mod; } vec_t;

    beat_t q0[$], q1[$];
    ev_t   fire_log[$], res_log[$];
    exp_t  ep [4];
    logic  fired0 = 1'b0, fired1 = 1'b0, prev_v0 = 1'b0, prev_v1 = 1'b0;
    int    rise0 = 0, rise1 = 0;

    // Requester drivers: hold valid while a beat is queued, pop after it fires.
    always begin
        @(posedge clk);
        #1;
        if (fired0 && q0.size() > 0) void'(q0.pop_front());
        if (fired1 && q1.size() > 0) void'(q1.pop_front());
        bus.r0_valid = q0.size() > 0;
        bus.r0_a     = q0.size() > 0 ? q0[0].a : 16'd0;
        bus.r0_b     = q0.size() > 0 ? q0[0].b : 16'd0;
        bus.r0_tag   = q0.size() > 0 ? q0[0].tag : 9'd0;
        bus.r1_valid = q1.size() > 0;
        bus.r1_a     = q1.size() > 0 ? q1[0].a : 16'd0;
        bus.r1_b     = q1.size() > 0 ? q1[0].b : 16'd0;
        bus.r1_tag   = q1.size() > 0 ? q1[0].tag : 9'd0;
    end

    // Per-cycle monitor: operand mux, grant exclusivity and result routing.
    always @(negedge clk) begin
        if (bus.r0_res_valid === 1'b1) res_log.push_back('{cyc, 1'b0, bus.r0_res_tag, bus.r0_res});
        if (bus.r1_res_valid === 1'b1) res_log.push_back('{cyc, 1'b1, bus.r1_res_tag, bus.r1_res});
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) ep[i] <= '0;
            fired0 <= 1'b0;
            fired1 <= 1'b0;
        end else begin
            automatic logic f0 = bus.r0_valid && bus.r0_ready;
            automatic logic f1 = bus.r1_valid && bus.r1_ready;
            automatic exp_t old = ep[3];
            automatic exp_t cur;
            automatic logic [15:0] ea = f0 ? bus.r0_a : (f1 ? bus.r1_a : 16'd0);
            automatic logic [15:0] eb = f0 ? bus.r0_b : (f1 ? bus.r1_b : 16'd0);
            cur.fire  = f0 || f1;
            cur.owner = f1;
            cur.tag   = f1 ? bus.r1_tag : bus.r0_tag;
            cur.val   = mont(ea, eb);
            ep[0] <= cur;
            ep[1] <= ep[0];
            ep[2] <= ep[1];
            ep[3] <= ep[2];
            fired0 <= f0;
            fired1 <= f1;
            check("mul_a", bus.mul_a, ea);
            check("mul_b", bus.mul_b, eb);
            check("ready_exclusive", bus.r0_ready & bus.r1_ready, 0);
            check("res_valid0", bus.r0_res_valid, old.fire & ~old.owner);
            check("res_valid1", bus.r1_res_valid, old.fire & old.owner);
            if (old.fire && !old.owner) begin
                check("res0", bus.r0_res, old.val);
                check("res_tag0", bus.r0_res_tag, old.tag);
            end
            if (old.fire && old.owner) begin
                check("res1", bus.r1_res, old.val);
                check("res_tag1", bus.r1_res_tag, old.tag);
            end
            if (cur.fire) fire_log.push_back('{cyc, f1, cur.tag, 16'd0});
            if (bus.r0_valid && !prev_v0) rise0 <= cyc;
            if (bus.r1_valid && !prev_v1) rise1 <= cyc;
            prev_v0 <= bus.r0_valid;
            prev_v1 <= bus.r1_valid;
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while ((q0.size() != 0 || q1.size() != 0 || bus.busy || bus.r0_valid || bus.r1_valid)
                   && n < budget);
        check("idle_timeout", n >= budget, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got still running, required finished");
        $fatal(1, "watchdog expired");
    end

    vec_t vt [6];
    int   n_fire, n_res, n, rres;
    int   off4 [6];
    bit   own4 [6];

    initial begin
        vt[0] = '{1'b0, 16'd2285, 16'd7,    9'd5,   7};
        vt[1] = '{1'b1, 16'd2285, 16'hFF9C, 9'd300, 3229};
        vt[2] = '{1'b0, 16'd1,    16'd2285, 9'd17,  1};
        vt[3] = '{1'b1, 16'd0,    16'd1234, 9'd511, 0};
        vt[4] = '{1'b0, 16'hF713, 16'd5,    9'd170, 3324};
        vt[5] = '{1'b1, 16'd2285, 16'd3328, 9'd256, 3328};
        off4 = '{0, 1, 2, 4, 5, 6};
        own4 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready0", bus.r0_ready, 0);
        check("rst_ready1", bus.r1_ready, 0);
        check("rst_res_valid0", bus.r0_res_valid, 0);
        check("rst_res_valid1", bus.r1_res_valid, 0);
        check("rst_res_tag", bus.r0_res_tag, 0);
        check("rst_mul_a", bus.mul_a, 0);
        check("rst_busy", bus.busy, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Single isolated beats: IDLE bubble, latency 4, routing, residue, zeros in idle cycles.
        for (int v = 0; v < 6; v++) begin
            n_fire = fire_log.size();
            n_res  = res_log.size();
            if (vt[v].owner) q1.push_back('{vt[v].a, vt[v].b, vt[v].tag});
            else             q0.push_back('{vt[v].a, vt[v].b, vt[v].tag});
            wait_idle(40);
            check("vec_fires", fire_log.size() - n_fire, 1);
            check("vec_results", res_log.size() - n_res, 1);
            if (fire_log.size() > n_fire && res_log.size() > n_res) begin
                rres = int'($signed(res_log[n_res].res));
                check("vec_bubble", fire_log[n_fire].cyc - (vt[v].owner ? rise1 : rise0), 1);
                check("vec_latency", res_log[n_res].cyc - fire_log[n_fire].cyc, 4);
                check("vec_owner", res_log[n_res].owner, vt[v].owner);
                check("vec_tag", res_log[n_res].tag, vt[v].tag);
                check("vec_residue", ((rres % KYBER_Q) + KYBER_Q) % KYBER_Q, vt[v].exp_mod);
                check("vec_range", (rres > -KYBER_Q) && (rres < KYBER_Q), 1);
            end
            repeat (3) begin
                @(posedge clk);
                #2;
                check("idle_mul_a", bus.mul_a, 0);
                check("idle_mul_b", bus.mul_b, 0);
                check("idle_res", bus.r0_res_valid | bus.r1_res_valid, 0);
            end
        end

        // Both requesters saturated: 8-beat bursts alternate with no gaps.
        n_fire = fire_log.size();
        n_res  = res_log.size();
        for (int i = 0; i < 32; i++) begin
            q0.push_back('{16'(i + 1), 16'(i + 2), 9'(i)});
            q1.push_back('{16'(i + 3), 16'(3 * i), 9'(100 + i)});
        end
        wait_idle(400);
        check("t2_fires", fire_log.size() - n_fire, 64);
        check("t2_results", res_log.size() - n_res, 64);
        if (fire_log.size() - n_fire == 64 && res_log.size() - n_res == 64) begin
            for (int k = 0; k < 64; k++) begin
                automatic int own = (k / 8) % 2;
                automatic int idx = (k / 16) * 8 + k % 8;
                check("t2_owner", fire_log[n_fire + k].owner, own);
                check("t2_gap", fire_log[n_fire + k].cyc - fire_log[n_fire].cyc, k);
                check("t2_res_owner", res_log[n_res + k].owner, own);
                check("t2_res_tag", res_log[n_res + k].tag, own != 0 ? 100 + idx : idx);
                check("t2_latency", res_log[n_res + k].cyc - fire_log[n_fire + k].cyc, 4);
            end
        end

        // Uncontended r1: burst counter saturates, no forced yield.
        n_fire = fire_log.size();
        n_res  = res_log.size();
        for (int i = 0; i < 20; i++) q1.push_back('{16'(i), 16'(i), 9'(i)});
        wait_idle(200);
        check("t3_fires", fire_log.size() - n_fire, 20);
        check("t3_results", res_log.size() - n_res, 20);
        if (fire_log.size() - n_fire == 20 && res_log.size() - n_res == 20) begin
            for (int k = 0; k < 20; k++) begin
                check("t3_owner", fire_log[n_fire + k].owner, 1);
                check("t3_gap", fire_log[n_fire + k].cyc - fire_log[n_fire].cyc, k);
                check("t3_res_tag", res_log[n_res + k].tag, k);
                check("t3_res_gap", res_log[n_res + k].cyc - res_log[n_res].cyc, k);
            end
        end

        // r0 drops valid mid-burst while r1 waits: one switch cycle, no lost beat.
        n_fire = fire_log.size();
        n_res  = res_log.size();
        for (int i = 0; i < 3; i++) begin
            q0.push_back('{16'(50 + i), 16'd9, 9'(400 + i)});
            q1.push_back('{16'(60 + i), 16'd11, 9'(410 + i)});
        end
        wait_idle(100);
        check("t4_fires", fire_log.size() - n_fire, 6);
        check("t4_results", res_log.size() - n_res, 6);
        if (fire_log.size() - n_fire == 6) begin
            for (int k = 0; k < 6; k++) begin
                check("t4_owner", fire_log[n_fire + k].owner, own4[k]);
                check("t4_offset", fire_log[n_fire + k].cyc - fire_log[n_fire].cyc, off4[k]);
            end
        end

        // Reset with three beats in flight: their results must never appear.
        n_fire = fire_log.size();
        n_res  = res_log.size();
        for (int i = 0; i < 3; i++) q0.push_back('{16'(70 + i), 16'd3, 9'(450 + i)});
        n = 0;
        while (fire_log.size() < n_fire + 3 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("t5_fired", fire_log.size() - n_fire, 3);
        reset_n = 1'b0;
        #1;
        check("t5_busy_in_reset", bus.busy, 0);
        check("t5_ready_in_reset", bus.r0_ready | bus.r1_ready, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        check("t5_no_results", res_log.size() - n_res, 0);
        check("t5_busy", bus.busy, 0);
        check("t5_idle_ready", bus.r0_ready | bus.r1_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
